// File: rtl/addr_reg_pkg.sv
// Shared types and constants for the parametrised address register.
// Reset values are single-bit fill patterns replicated across the address width.
package addr_reg_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_SRC    = 2;

    localparam logic ADDR_RST  = 1'b0;
    localparam logic BASE_RST  = 1'b0;
    localparam logic LIMIT_RST = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLR,
        OP_WR,
        OP_INC
    } op_e;

endpackage

// File: rtl/addr_src_mux.sv
// Lowest-index priority selector across the N write sources.
// Also reports whether any source, or more than one source, is writing.
module addr_src_mux
    import addr_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_SRC    = DEF_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]            write_en,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] data_in,
    output logic                          any_wr,
    output logic [DATA_WIDTH-1:0]         sel_data,
    output logic                          multi_wr
);

    logic found;
    logic seen;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_data = '0;
        found    = 1'b0;
        seen     = 1'b0;
        multi_wr = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (write_en[i] && !found) begin
                sel_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                found    = 1'b1;
            end
            multi_wr = multi_wr | (seen & write_en[i]);
            seen     = seen | write_en[i];
        end
    end

    assign any_wr = |write_en;

endmodule

// File: rtl/param_address_register.sv
// Address pointer with N-source load, stride auto-increment and base/limit wrap.
// Define ADDR_REG_COLLISION_DET_EN to build the sticky multi-write collision flag.
module param_address_register
    import addr_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_SRC    = DEF_NUM_SRC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            write_en,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] data_in,
    input  logic                          clr_en,
    input  logic                          inc_en,
    input  logic [DATA_WIDTH-1:0]         stride,
    input  logic                          base_we,
    input  logic                          limit_we,
    input  logic [DATA_WIDTH-1:0]         cfg_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          at_limit,
    output logic                          wrap_pulse,
    output logic                          collision
);

    logic [DATA_WIDTH-1:0] ptr_q;
    logic [DATA_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] limit_q;
    logic                  wrap_q;

    logic                  any_wr;
    logic                  multi_wr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH:0]   sum;
    logic                  overrun;
    op_e                   op;

    addr_src_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SRC    (NUM_SRC)
    ) u_src_mux (
        .write_en (write_en),
        .data_in  (data_in),
        .any_wr   (any_wr),
        .sel_data (sel_data),
        .multi_wr (multi_wr)
    );

    // Extra bit keeps the carry, so an overflowing add always counts as an overrun.
    assign sum     = {1'b0, ptr_q} + {1'b0, stride};
    assign overrun = sum > {1'b0, limit_q};

    always_comb begin
        op = OP_HOLD;
        if (clr_en) begin
            op = OP_CLR;
        end else if (any_wr) begin
            op = OP_WR;
        end else if (inc_en) begin
            op = OP_INC;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge base/limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= {DATA_WIDTH{ADDR_RST}};
            base_q  <= {DATA_WIDTH{BASE_RST}};
            limit_q <= {DATA_WIDTH{LIMIT_RST}};
            wrap_q  <= 1'b0;
        end else begin
            if (base_we) begin
                base_q <= cfg_in;
            end
            if (limit_we) begin
                limit_q <= cfg_in;
            end
            wrap_q <= 1'b0;
            case (op)
                OP_CLR: ptr_q <= base_q;
                OP_WR:  ptr_q <= sel_data;
                OP_INC: begin
                    if (overrun) begin
                        ptr_q  <= base_q;
                        wrap_q <= 1'b1;
                    end else begin
                        ptr_q <= sum[DATA_WIDTH-1:0];
                    end
                end
                default: ptr_q <= ptr_q;
            endcase
        end
    end

    assign data_out   = ptr_q;
    assign at_limit   = (ptr_q == limit_q);
    assign wrap_pulse = wrap_q;

`ifdef ADDR_REG_COLLISION_DET_EN
    logic collision_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else if (multi_wr) begin
            collision_q <= 1'b1;
        end
    end

    assign collision = collision_q;
`else
    logic unused_multi_wr;

    assign unused_multi_wr = multi_wr;
    assign collision       = 1'b0;
`endif

endmodule

// File: tb/tb_param_address_register.sv
// Directed self-checking bench for param_address_register (DATA_WIDTH=16, NUM_SRC=2).
// Collision expectations follow ADDR_REG_COLLISION_DET_EN.
module tb_param_address_register;

    localparam int DW = 16;
    localparam int NS = 2;

`ifdef ADDR_REG_COLLISION_DET_EN
    localparam logic COLL_EN = 1'b1;
`else
    localparam logic COLL_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [NS-1:0]    write_en;
    logic [NS*DW-1:0] data_in;
    logic             clr_en;
    logic             inc_en;
    logic [DW-1:0]    stride;
    logic             base_we;
    logic             limit_we;
    logic [DW-1:0]    cfg_in;
    logic [DW-1:0]    data_out;
    logic             at_limit;
    logic             wrap_pulse;
    logic             collision;

    int total = 0;
    int bad   = 0;

    param_address_register #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_en   (write_en),
        .data_in    (data_in),
        .clr_en     (clr_en),
        .inc_en     (inc_en),
        .stride     (stride),
        .base_we    (base_we),
        .limit_we   (limit_we),
        .cfg_in     (cfg_in),
        .data_out   (data_out),
        .at_limit   (at_limit),
        .wrap_pulse (wrap_pulse),
        .collision  (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        write_en = '0;
        data_in  = '0;
        clr_en   = 1'b0;
        inc_en   = 1'b0;
        stride   = '0;
        base_we  = 1'b0;
        limit_we = 1'b0;
        cfg_in   = '0;
    endtask

    // Apply the currently driven inputs for one edge, then return them to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [NS-1:0] en, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        write_en = en;
        data_in  = {d1, d0};
        tick();
    endtask

    task automatic inc(input logic [DW-1:0] s);
        inc_en = 1'b1;
        stride = s;
        tick();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_data_out", data_out, 16'h0000);
        check_bit("rst_at_limit", at_limit, 1'b0);
        check_bit("rst_wrap", wrap_pulse, 1'b0);
        check_bit("rst_collision", collision, 1'b0);

        inc(16'hFFFF);
        check("inc_to_limit", data_out, 16'hFFFF);
        check_bit("inc_to_limit_at", at_limit, 1'b1);
        check_bit("inc_to_limit_wrap", wrap_pulse, 1'b0);

        wr(2'b01, 16'd100, 16'd0);
        check("wr_src0", data_out, 16'd100);
        wr(2'b10, 16'd0, 16'd127);
        check("wr_src1", data_out, 16'd127);
        check_bit("no_collision_single", collision, 1'b0);
        wr(2'b11, 16'd15, 16'd10);
        check("wr_both_low_wins", data_out, 16'd15);
        check_bit("collision_set", collision, COLL_EN);

        base_we = 1'b1; cfg_in = 16'd50;  tick();
        limit_we = 1'b1; cfg_in = 16'd200; tick();
        wr(2'b01, 16'd190, 16'd0);
        check("wr_190", data_out, 16'd190);
        inc(16'd8);
        check("inc_198", data_out, 16'd198);
        check_bit("inc_198_wrap", wrap_pulse, 1'b0);
        check_bit("inc_198_at", at_limit, 1'b0);
        inc(16'd8);
        check("wrap_to_base", data_out, 16'd50);
        check_bit("wrap_pulse_hi", wrap_pulse, 1'b1);
        check_bit("wrap_at", at_limit, 1'b0);
        tick();
        check_bit("wrap_pulse_one_cycle", wrap_pulse, 1'b0);
        check("hold_after_wrap", data_out, 16'd50);

        wr(2'b01, 16'd200, 16'd0);
        inc(16'd0);
        check("stride0_at_limit_hold", data_out, 16'd200);
        check_bit("stride0_at_limit_at", at_limit, 1'b1);
        check_bit("stride0_at_limit_wrap", wrap_pulse, 1'b0);
        wr(2'b10, 16'd0, 16'd210);
        check("wr_above_limit", data_out, 16'd210);
        inc(16'd0);
        check("stride0_over_limit_wraps", data_out, 16'd50);
        check_bit("stride0_over_limit_pulse", wrap_pulse, 1'b1);

        base_we = 1'b1; cfg_in = 16'd250; tick();
        clr_en = 1'b1; tick();
        check("clr_base_above_limit", data_out, 16'd250);
        inc(16'd0);
        check("wrap_base_above_limit", data_out, 16'd250);
        check_bit("b2b_wrap_1", wrap_pulse, 1'b1);
        inc(16'd0);
        check_bit("b2b_wrap_2", wrap_pulse, 1'b1);
        base_we = 1'b1; cfg_in = 16'd50; tick();

        clr_en = 1'b1; write_en = 2'b01; data_in = {16'd0, 16'd999};
        inc_en = 1'b1; stride = 16'd1; base_we = 1'b1; cfg_in = 16'd7;
        tick();
        check("clr_uses_old_base", data_out, 16'd50);
        clr_en = 1'b1; tick();
        check("clr_new_base", data_out, 16'd7);
        check_bit("collision_survives_clr", collision, COLL_EN);

        write_en = 2'b10; data_in = {16'd300, 16'd0}; inc_en = 1'b1; stride = 16'd1;
        tick();
        check("wr_beats_inc", data_out, 16'd300);

        limit_we = 1'b1; cfg_in = 16'hFFFF; tick();
        wr(2'b01, 16'hFFF0, 16'd0);
        inc(16'h0020);
        check("carry_wraps", data_out, 16'd7);
        check_bit("carry_wrap_pulse", wrap_pulse, 1'b1);

        inc(16'd1);
        check("inc_before_reset", data_out, 16'd8);
        inc(16'hFFFF);
        check_bit("wrap_before_reset", wrap_pulse, 1'b1);
        rst_n = 1'b0; inc_en = 1'b1; stride = 16'd1; write_en = 2'b11; data_in = {16'd5, 16'd6};
        tick();
        rst_n = 1'b1;
        check("mid_reset_data_out", data_out, 16'h0000);
        check_bit("mid_reset_wrap", wrap_pulse, 1'b0);
        check_bit("mid_reset_collision", collision, 1'b0);
        wr(2'b01, 16'd33, 16'd0);
        clr_en = 1'b1; tick();
        check("reset_base_zero", data_out, 16'h0000);
        inc(16'hFFFF);
        check("reset_limit_ones", data_out, 16'hFFFF);
        check_bit("reset_limit_at", at_limit, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
